// File: rtl/config_bitstream_loader.sv
// Serial configuration bitstream loader at the array edge.
// Each frame carries an address and a data word, both MSB first. A complete
// frame becomes one broadcast config_data word plus a single-cycle one-hot
// config_en to the addressed tile. The all-ones address marks END and has no
// data field.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | not armed, bs_ready low, waiting for start
// S_ADDR  | shifting in ADDR_W address bits
// S_DATA  | shifting in DATA_W data bits
// S_WRITE | one cycle: strobe config_en (or flag error), bs_ready low
// S_DONE  | END seen, done high, waiting for start to re-arm
module config_bitstream_loader #(
   parameter int NUM_TILES = 16,
   parameter int ADDR_W    = 4,
   parameter int DATA_W    = 32
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic                 bs_valid,
   input  logic                 bs_bit,
   output logic                 bs_ready,
   output logic [DATA_W-1:0]    config_data,
   output logic [NUM_TILES-1:0] config_en,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic [15:0]          write_count
);

   localparam int MAX_W = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
   localparam int CNT_W = $clog2(MAX_W + 1);

   localparam logic [ADDR_W-1:0] END_ADDR   = '1;
   localparam logic [ADDR_W:0]   TILE_LIMIT = (ADDR_W + 1)'(NUM_TILES);
   localparam logic [CNT_W-1:0]  ADDR_LOAD  = CNT_W'(ADDR_W - 1);
   localparam logic [CNT_W-1:0]  DATA_LOAD  = CNT_W'(DATA_W - 1);
   localparam logic [NUM_TILES-1:0] EN_ONE  = {{(NUM_TILES - 1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_WRITE,
      S_DONE
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   bit_cnt;
   logic [ADDR_W-1:0]  addr_sr;
   logic [DATA_W-1:0]  data_sr;

   logic               accept;
   logic [ADDR_W-1:0]  addr_next;
   logic [DATA_W-1:0]  data_next;
   logic               in_range;

   assign accept = bs_valid && bs_ready;

   // Shift-register next values and tile range check on the latched address.
   always_comb begin
      addr_next = {addr_sr[ADDR_W-2:0], bs_bit};
      data_next = {data_sr[DATA_W-2:0], bs_bit};
      in_range  = ({1'b0, addr_sr} < TILE_LIMIT);
   end

   // Frame sequencer; bit_cnt is a down-counter loaded per field, field ends at zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         bit_cnt     <= '0;
         addr_sr     <= '0;
         data_sr     <= '0;
         bs_ready    <= 1'b0;
         config_data <= '0;
         config_en   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
         write_count <= '0;
      end else begin
         config_en <= '0;
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state       <= S_ADDR;
                  bit_cnt     <= ADDR_LOAD;
                  bs_ready    <= 1'b1;
                  busy        <= 1'b1;
                  done        <= 1'b0;
                  error       <= 1'b0;
                  write_count <= '0;
               end
            end

            S_ADDR: begin
               if (accept) begin
                  addr_sr <= addr_next;
                  if (bit_cnt == '0) begin
                     if (addr_next == END_ADDR) begin
                        state    <= S_DONE;
                        bs_ready <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                     end else begin
                        state   <= S_DATA;
                        bit_cnt <= DATA_LOAD;
                     end
                  end else begin
                     bit_cnt <= bit_cnt - 1'b1;
                  end
               end
            end

            S_DATA: begin
               if (accept) begin
                  data_sr <= data_next;
                  if (bit_cnt == '0) begin
                     // Strobe and bookkeeping are registered here so they are
                     // visible exactly during the WRITE cycle.
                     state       <= S_WRITE;
                     bs_ready    <= 1'b0;
                     config_data <= data_next;
                     if (in_range) begin
                        config_en <= EN_ONE << addr_sr;
                        if (write_count != 16'hFFFF) begin
                           write_count <= write_count + 16'd1;
                        end
                     end else begin
                        error <= 1'b1;
                     end
                  end else begin
                     bit_cnt <= bit_cnt - 1'b1;
                  end
               end
            end

            S_WRITE: begin
               state    <= S_ADDR;
               bit_cnt  <= ADDR_LOAD;
               bs_ready <= 1'b1;
            end

            default: begin
               state    <= S_IDLE;
               bs_ready <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_config_bitstream_loader.sv
// Bench for config_bitstream_loader. Two instances share one serial stream:
// instance a drives 16 tiles, instance b drives 12 tiles, both with a 5-bit
// address field so every tile index 0..15 is reachable and END is 31.
module tb_config_bitstream_loader;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int END_A = 31;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic start = 1'b0;
   logic bs_valid = 1'b0;
   logic bs_bit = 1'b0;

   logic        rdy_a, busy_a, done_a, err_a;
   logic [31:0] data_a;
   logic [15:0] en_a;
   logic [15:0] wc_a;
   logic        rdy_b, busy_b, done_b, err_b;
   logic [31:0] data_b;
   logic [11:0] en_b;
   logic [15:0] wc_b;

   config_bitstream_loader #(.NUM_TILES(16), .ADDR_W(AW), .DATA_W(DW)) u_dut_a (
      .clk(clk), .reset_n(reset_n), .start(start), .bs_valid(bs_valid), .bs_bit(bs_bit),
      .bs_ready(rdy_a), .config_data(data_a), .config_en(en_a), .busy(busy_a),
      .done(done_a), .error(err_a), .write_count(wc_a));

   config_bitstream_loader #(.NUM_TILES(12), .ADDR_W(AW), .DATA_W(DW)) u_dut_b (
      .clk(clk), .reset_n(reset_n), .start(start), .bs_valid(bs_valid), .bs_bit(bs_bit),
      .bs_ready(rdy_b), .config_data(data_b), .config_en(en_b), .busy(busy_b),
      .done(done_b), .error(err_b), .write_count(wc_b));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_err = 0;
   int n_chk = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: expected writes per instance, counts, sticky error, last word.
   typedef struct {
      int          addr;
      logic [31:0] data;
   } wr_t;

   wr_t         q_a[$];
   wr_t         q_b[$];
   wr_t         w_a, w_b;
   int          exp_wc_a = 0, exp_wc_b = 0;
   bit          exp_err_a = 0, exp_err_b = 0;
   logic [31:0] exp_data = '0;
   int          first_cyc = 0;
   int          last_en_cyc = 0;

   // Every nonzero strobe must match the next expected write of that instance.
   always @(negedge clk) begin
      if (en_a != '0) begin
         last_en_cyc = cyc;
         if (q_a.size() == 0) check_val("en_a_unexpected", 64'(en_a), 64'(0));
         else begin
            w_a = q_a.pop_front();
            check_val("en_a", 64'(en_a), 64'(1) << w_a.addr);
            check_val("data_a", 64'(data_a), 64'(w_a.data));
         end
      end
      if (en_b != '0) begin
         if (q_b.size() == 0) check_val("en_b_unexpected", 64'(en_b), 64'(0));
         else begin
            w_b = q_b.pop_front();
            check_val("en_b", 64'(en_b), 64'(1) << w_b.addr);
            check_val("data_b", 64'(data_b), 64'(w_b.data));
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // mode 0: valid always, 1: valid every other cycle, 2: random valid.
   task automatic send_stream(input logic [63:0] bits, input int n, input int mode, input int start_at);
      int  i = 0;
      int  k = 0;
      bit  started = 0;
      logic v, rdy;
      while (i < n) begin
         if (k > 400) begin
            check_val("drv_timeout", 64'(i), 64'(n));
            bs_valid = 1'b0;
            start = 1'b0;
            return;
         end
         rdy = rdy_a;
         case (mode)
            0: v = 1'b1;
            1: v = (k % 2 == 0);
            default: v = 1'($urandom_range(0, 1));
         endcase
         bs_valid = v;
         bs_bit = bits[n-1-i];
         start = (i == start_at) && !started;
         if (start) started = 1;
         if (i == 0 && v && rdy) first_cyc = cyc;
         @(posedge clk);
         #1;
         if (v && rdy) i++;
         k++;
      end
      bs_valid = 1'b0;
      start = 1'b0;
   endtask

   task automatic frame(input int addr, input logic [31:0] data, input int mode, input int start_at);
      logic [63:0] bits;
      if (addr == END_A) begin
         bits = 64'(addr);
         send_stream(bits, AW, mode, start_at);
      end else begin
         bits = (64'(addr) << DW) | 64'(data);
         if (addr < 16) begin
            q_a.push_back('{addr, data});
            if (exp_wc_a < 65535) exp_wc_a++;
         end else exp_err_a = 1;
         if (addr < 12) begin
            q_b.push_back('{addr, data});
            if (exp_wc_b < 65535) exp_wc_b++;
         end else exp_err_b = 1;
         exp_data = data;
         send_stream(bits, AW + DW, mode, start_at);
      end
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      exp_wc_a = 0;
      exp_wc_b = 0;
      exp_err_a = 0;
      exp_err_b = 0;
   endtask

   task automatic check_status(input string tag, input bit exp_done);
      logic [2:0] fl;
      fl = {exp_done, ~exp_done, ~exp_done};
      check_val({tag, "_wc_a"}, 64'(wc_a), 64'(exp_wc_a));
      check_val({tag, "_wc_b"}, 64'(wc_b), 64'(exp_wc_b));
      check_val({tag, "_err_a"}, 64'(err_a), 64'(exp_err_a));
      check_val({tag, "_err_b"}, 64'(err_b), 64'(exp_err_b));
      check_val({tag, "_flags_a"}, 64'({done_a, busy_a, rdy_a}), 64'(fl));
      check_val({tag, "_flags_b"}, 64'({done_b, busy_b, rdy_b}), 64'(fl));
      check_val({tag, "_data_a"}, 64'(data_a), 64'(exp_data));
      check_val({tag, "_data_b"}, 64'(data_b), 64'(exp_data));
      check_val({tag, "_pending_a"}, 64'(q_a.size()), 64'(0));
      check_val({tag, "_pending_b"}, 64'(q_b.size()), 64'(0));
   endtask

   task automatic check_zero(input string tag);
      check_val({tag, "_a"}, 64'({rdy_a, busy_a, done_a, err_a, wc_a, en_a}), 64'(0));
      check_val({tag, "_b"}, 64'({rdy_b, busy_b, done_b, err_b, wc_b, en_b}), 64'(0));
      check_val({tag, "_data_a"}, 64'(data_a), 64'(0));
      check_val({tag, "_data_b"}, 64'(data_b), 64'(0));
   endtask

   initial begin
      logic [31:0] d;
      int          a;
      reset_n = 1'b0;
      idle(3);
      check_zero("reset");
      reset_n = 1'b1;
      idle(2);
      check_zero("idle");

      // Single frame, continuous valid, latency from first accepted bit.
      do_start();
      check_val("t1_armed", 64'({rdy_a, busy_a, rdy_b, busy_b}), 64'(4'hF));
      frame(3, 32'hDEADBEEF, 0, -1);
      idle(2);
      check_val("t1_latency", 64'(last_en_cyc - first_cyc), 64'(AW + DW));
      check_status("t1", 0);
      frame(END_A, '0, 0, -1);
      check_status("t1_end", 1);

      // Tiles 0, 15, 7 then END.
      do_start();
      frame(0, 32'h0000_0001, 0, -1);
      frame(15, 32'hA5A5_0F0F, 0, -1);
      frame(7, 32'h1234_5678, 0, -1);
      frame(END_A, '0, 0, -1);
      check_status("t2", 1);

      // Out-of-range address for the 12-tile instance, then a normal write.
      do_start();
      frame(13, 32'hCAFE_F00D, 0, -1);
      idle(2);
      check_status("t3_drop", 0);
      frame(2, 32'h0BAD_BEEF, 0, -1);
      frame(END_A, '0, 0, -1);
      check_status("t3", 1);

      // Valid toggling every cycle doubles the frame time.
      do_start();
      frame(3, 32'hDEADBEEF, 1, -1);
      idle(2);
      check_val("t4_latency", 64'(last_en_cyc - first_cyc), 64'(2 * (AW + DW) - 1));
      check_status("t4", 0);
      frame(END_A, '0, 1, -1);
      check_status("t4_end", 1);

      // start during DATA is ignored; start in DONE re-arms and clears.
      do_start();
      frame(9, 32'h5555_AAAA, 0, 10);
      frame(20, 32'h7777_8888, 0, -1);
      frame(END_A, '0, 0, -1);
      check_status("t6", 1);
      do_start();
      check_status("t6_rearm", 0);

      // Randomized frames with random valid gaps.
      for (int n = 0; n < 10; n++) begin
         a = $urandom_range(0, 30);
         d = $urandom;
         frame(a, d, $urandom_range(0, 2), -1);
      end
      frame(END_A, '0, 2, -1);
      check_status("t7", 1);

      // Reset after 20 data bits: partial frame lost, stays idle until start.
      do_start();
      send_stream((64'(5) << 20) | 64'(20'hFACEB), AW + 20, 0, -1);
      #3;
      reset_n = 1'b0;
      #1;
      check_zero("t5_rst");
      exp_data = '0;
      exp_wc_a = 0;
      exp_wc_b = 0;
      exp_err_a = 0;
      exp_err_b = 0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      for (int n = 0; n < 30; n++) begin
         bs_valid = 1'($urandom_range(0, 1));
         bs_bit = 1'($urandom_range(0, 1));
         idle(1);
      end
      bs_valid = 1'b0;
      check_zero("t5_idle");
      do_start();
      frame(6, 32'h600D_0006, 2, -1);
      frame(END_A, '0, 2, -1);
      check_status("t5_after", 1);

      idle(3);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
